// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job scheduler: FSM encoding and
// default operand width / watchdog limit.
package gcd_pkg;

    localparam int GCD_W       = 8;
    localparam int GCD_TIMEOUT = 300;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } state_t;

endpackage

// File: rtl/gcd_job_fifo.sv
// Job FIFO holding {A,B} operand pairs; DEPTH must be a power of two
// so the read/write pointers wrap naturally.
module gcd_job_fifo
    import gcd_pkg::*;
#(
    parameter int W     = GCD_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_a,
    input  logic [W-1:0] push_b,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_a,
    output logic [W-1:0] head_b
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign {head_a, head_b} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_a, push_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Queues operand pairs, issues them to the GCD core one at a time with a
// watchdog, and returns results in order. Define GCD_JOB_STATS_EN for counters.
module gcd_job_scheduler
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] IN_A,
    input  logic [W-1:0] IN_B,
    output logic [W-1:0] GCD_A,
    output logic [W-1:0] GCD_B,
    output logic         GCD_START,
    input  logic [W-1:0] GCD_Y,
    input  logic         GCD_DONE,
    input  logic         GCD_ERROR,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] OUT_Y,
    output logic         OUT_ERR,
`ifdef GCD_JOB_STATS_EN
    output logic [15:0]  JOB_CNT,
    output logic [15:0]  ERR_CNT,
`endif
    output logic         BUSY
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    // The START cycle is the first of TIMEOUT cycles, so WAIT gives up
    // on its (TIMEOUT-1)th cycle and OUT_VALID lands TIMEOUT cycles after START.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

    state_t         state;
    state_t         state_nx;
    logic [WDW-1:0] wd;
    logic           full;
    logic           empty;
    logic           pop;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;
    logic           wd_hit;

    assign IN_READY  = !full;
    assign GCD_START = (state == ISSUE);
    assign OUT_VALID = (state == HOLD);
    assign BUSY      = !empty || (state != IDLE);
    assign wd_hit    = (wd == WD_LAST);

    gcd_job_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst_n  (RST_N),
        .push   (IN_VALID),
        .pop    (pop),
        .push_a (IN_A),
        .push_b (IN_B),
        .full   (full),
        .empty  (empty),
        .head_a (head_a),
        .head_b (head_b)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx = ISSUE;
                    pop      = 1'b1;
                end
            end
            ISSUE:   state_nx = WAIT;
            WAIT:    if (GCD_DONE || wd_hit) state_nx = HOLD;
            HOLD:    if (OUT_READY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            GCD_A   <= '0;
            GCD_B   <= '0;
            wd      <= '0;
            OUT_Y   <= '0;
            OUT_ERR <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) begin
                GCD_A <= head_a;
                GCD_B <= head_b;
            end
            if (state == ISSUE) wd <= '0;
            else if (state == WAIT) wd <= wd + WDW'(1);
            if (state == WAIT) begin
                if (GCD_DONE) begin
                    OUT_Y   <= GCD_Y;
                    OUT_ERR <= GCD_ERROR;
                end else if (wd_hit) begin
                    OUT_Y   <= '0;
                    OUT_ERR <= 1'b1;
                end
            end
        end
    end

`ifdef GCD_JOB_STATS_EN
    logic out_hs;
    assign out_hs = OUT_VALID && OUT_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            JOB_CNT <= '0;
            ERR_CNT <= '0;
        end else begin
            if (out_hs && JOB_CNT != 16'hFFFF)
                JOB_CNT <= JOB_CNT + 16'd1;
            if (out_hs && OUT_ERR && ERR_CNT != 16'hFFFF)
                ERR_CNT <= ERR_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Bench for gcd_job_scheduler: behavioural GCD core, result scoreboard,
// table vectors, hand-written corner sequences and random jobs.
module tb_gcd_job_scheduler;

    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 300;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] IN_A = '0;
    logic [W-1:0] IN_B = '0;
    logic [W-1:0] GCD_A;
    logic [W-1:0] GCD_B;
    logic         GCD_START;
    logic [W-1:0] GCD_Y;
    logic         GCD_DONE;
    logic         GCD_ERROR;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b1;
    logic [W-1:0] OUT_Y;
    logic         OUT_ERR;
    logic         BUSY;
`ifdef GCD_JOB_STATS_EN
    logic [15:0]  JOB_CNT;
    logic [15:0]  ERR_CNT;
`endif

    gcd_job_scheduler #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .GCD_A     (GCD_A),
        .GCD_B     (GCD_B),
        .GCD_START (GCD_START),
        .GCD_Y     (GCD_Y),
        .GCD_DONE  (GCD_DONE),
        .GCD_ERROR (GCD_ERROR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_Y     (OUT_Y),
        .OUT_ERR   (OUT_ERR),
`ifdef GCD_JOB_STATS_EN
        .JOB_CNT   (JOB_CNT),
        .ERR_CNT   (ERR_CNT),
`endif
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] y;
        logic       err;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       err;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   start_cnt = 0;
    int   hs_cnt = 0;
    int   err_hs_cnt = 0;
    logic stub = 1'b0;
    res_t exp_q[$];
    res_t mon_e;
    vec_t tbl[10];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void fail(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endfunction

    function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return 8'(x);
    endfunction

    // behavioural core: variable latency, flags operand changes while busy
    logic       core_busy = 1'b0;
    int         core_left = 0;
    logic [7:0] ca = '0;
    logic [7:0] cb = '0;
    logic       hold_bad = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            GCD_DONE  <= 1'b0;
            GCD_Y     <= '0;
            GCD_ERROR <= 1'b0;
            core_busy <= 1'b0;
        end else begin
            GCD_DONE <= 1'b0;
            if (GCD_START && !stub) begin
                core_busy <= 1'b1;
                ca        <= GCD_A;
                cb        <= GCD_B;
                core_left <= int'(GCD_A % 5) + 2;
                hold_bad  <= 1'b0;
            end else if (core_busy) begin
                if (GCD_A != ca || GCD_B != cb) hold_bad <= 1'b1;
                if (core_left == 0) begin
                    core_busy <= 1'b0;
                    GCD_DONE  <= 1'b1;
                    GCD_ERROR <= (ca == 0 || cb == 0);
                    GCD_Y     <= (ca == 0 || cb == 0) ? 8'd0 : gcd_ref(ca, cb);
                end else begin
                    core_left <= core_left - 1;
                end
            end
        end
    end

    // scoreboard / monitor, sampling 1 time unit after the falling edge
    logic done_last = 1'b0;

    always begin
        @(negedge CLK);
        #1;
        if (RST_N) begin
            if (GCD_START) start_cnt++;
            if (done_last) begin
                check("valid_after_done", OUT_VALID, 1);
                check("operands_held", hold_bad, 0);
            end
            if (OUT_VALID && OUT_READY) begin
                hs_cnt++;
                if (OUT_ERR) err_hs_cnt++;
                if (exp_q.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_y", OUT_Y, mon_e.y);
                    check("out_err", OUT_ERR, mon_e.err);
                end
            end
        end
        done_last = GCD_DONE && RST_N;
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] y, input logic err);
        int   n = 0;
        res_t r;
        IN_VALID = 1'b1;
        IN_A     = a;
        IN_B     = b;
        while (!IN_READY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            fail("push_wait");
        end else begin
            r.y   = y;
            r.err = err;
            exp_q.push_back(r);
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 5000) fail("drain_wait");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!OUT_VALID && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (!OUT_VALID) fail("valid_wait");
    endtask

    initial begin
        int s0;
        int n;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rerr;

        tbl[0] = '{8'd12,  8'd18, 8'd6,  1'b0};
        tbl[1] = '{8'd0,   8'd5,  8'd0,  1'b1};
        tbl[2] = '{8'd35,  8'd21, 8'd7,  1'b0};
        tbl[3] = '{8'd48,  8'd36, 8'd12, 1'b0};
        tbl[4] = '{8'd7,   8'd7,  8'd7,  1'b0};
        tbl[5] = '{8'd255, 8'd1,  8'd1,  1'b0};
        tbl[6] = '{8'd9,   8'd6,  8'd3,  1'b0};
        tbl[7] = '{8'd5,   8'd0,  8'd0,  1'b1};
        tbl[8] = '{8'd100, 8'd75, 8'd25, 1'b0};
        tbl[9] = '{8'd17,  8'd13, 8'd1,  1'b0};

        repeat (3) @(negedge CLK);
        check("rst_in_ready", IN_READY, 1);
        check("rst_start", GCD_START, 0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_gcd_a", GCD_A, 0);
        check("rst_gcd_b", GCD_B, 0);
        check("rst_out_y", OUT_Y, 0);
        check("rst_out_err", OUT_ERR, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // push-to-START latency with the first table entry
        IN_VALID = 1'b1;
        IN_A = tbl[0].a;
        IN_B = tbl[0].b;
        exp_q.push_back('{tbl[0].y, tbl[0].err});
        @(negedge CLK);
        IN_VALID = 1'b0;
        check("lat_start_n1", GCD_START, 0);
        check("lat_busy_n1", BUSY, 1);
        @(negedge CLK);
        check("lat_start_n2", GCD_START, 1);
        check("lat_gcd_a", GCD_A, 12);
        check("lat_gcd_b", GCD_B, 18);
        @(negedge CLK);
        check("lat_start_n3", GCD_START, 0);
        drain();

        // remaining table entries back-to-back
        s0 = start_cnt;
        for (int i = 1; i < 10; i++)
            push(tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].err);
        drain();
        check("tbl_starts", start_cnt - s0, 9);

        // backpressure: one job held at output, four filling the FIFO
        OUT_READY = 1'b0;
        s0 = start_cnt;
        push(8'd20, 8'd15, 8'd5, 1'b0);
        wait_valid();
        push(8'd40, 8'd24, 8'd8, 1'b0);
        push(8'd21, 8'd14, 8'd7, 1'b0);
        push(8'd13, 8'd26, 8'd13, 1'b0);
        push(8'd0,  8'd9,  8'd0, 1'b1);
        check("bp_full", IN_READY, 0);
        IN_VALID = 1'b1;
        IN_A = 8'd30;
        IN_B = 8'd12;
        repeat (10) @(negedge CLK);
        check("bp_still_full", IN_READY, 0);
        check("bp_valid_held", OUT_VALID, 1);
        check("bp_y_held", OUT_Y, 5);
        check("bp_one_start", start_cnt - s0, 1);
        OUT_READY = 1'b1;
        push(8'd30, 8'd12, 8'd6, 1'b0);
        drain();
        check("bp_starts", start_cnt - s0, 6);

        // watchdog: core never answers
        stub = 1'b1;
        push(8'd20, 8'd8, 8'd0, 1'b1);
        n = 0;
        while (!GCD_START && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!GCD_START) fail("to_start_wait");
        n = 0;
        while (!OUT_VALID && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("to_cycles", n, TIMEOUT);
        check("to_out_y", OUT_Y, 0);
        check("to_out_err", OUT_ERR, 1);
        drain();

        // reset during WAIT with two jobs queued
        push(8'd50, 8'd10, 8'd10, 1'b0);
        push(8'd60, 8'd15, 8'd15, 1'b0);
        push(8'd70, 8'd14, 8'd14, 1'b0);
        repeat (3) @(negedge CLK);
        check("mid_busy", BUSY, 1);
        check("mid_full_not", IN_READY, 1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_start", GCD_START, 0);
        check("mid_rst_in_ready", IN_READY, 1);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_gcd_a", GCD_A, 0);
        check("mid_rst_out_valid", OUT_VALID, 0);
        exp_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        stub = 1'b0;
        hs_cnt = 0;
        err_hs_cnt = 0;
        s0 = start_cnt;
        repeat (20) @(negedge CLK);
        check("post_rst_no_start", start_cnt - s0, 0);
        check("post_rst_idle", BUSY, 0);
        push(8'd24, 8'd16, 8'd8, 1'b0);
        drain();

        // random jobs with random output backpressure
        s0 = start_cnt;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            if ($urandom_range(0, 7) == 0) ra = 8'd0;
            rerr = (ra == 0 || rb == 0);
            OUT_READY = IN_READY ? ($urandom_range(0, 3) != 0) : 1'b1;
            push(ra, rb, rerr ? 8'd0 : gcd_ref(ra, rb), rerr);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        OUT_READY = 1'b1;
        drain();
        check("rnd_starts", start_cnt - s0, 40);

`ifdef GCD_JOB_STATS_EN
        check("job_cnt", JOB_CNT, hs_cnt);
        check("err_cnt", ERR_CNT, err_hs_cnt);
`endif
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_job_scheduler.md
# gcd_job_scheduler

Upstream/downstream companion to the `GCD` core. It accepts operand pairs on a valid/ready input and buffers them in a small FIFO. It issues them one at a time to `GCD` through its A/B/START port and holds the operands stable until DONE. It then captures Y/ERROR and presents each result on a valid/ready output, in arrival order. It also guards against a hung core with a watchdog.

## Interface
- `W`, 8: operand/result width; must match `GCD`.
- `DEPTH`, 4: job FIFO entries; power of two, ≥2.
- `TIMEOUT`, 300: max cycles in WAIT before the job is aborted; ≥ 2^W + 8.

- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `IN_VALID` in 1: job offered.
- `IN_READY` out 1: FIFO not full.
- `IN_A`, `IN_B` in W: job operands.
- `GCD_A`, `GCD_B` out W: operands to core.
- `GCD_START` out 1: one-cycle start pulse to core.
- `GCD_Y` in W: core result.
- `GCD_DONE` in 1: core completion pulse.
- `GCD_ERROR` in 1: core error flag, valid with DONE.
- `OUT_VALID` out 1: result available.
- `OUT_READY` in 1: consumer accepts.
- `OUT_Y` out W: result value.
- `OUT_ERR` out 1: zero operand or timeout.
- `BUSY` out 1: FIFO non-empty or FSM not IDLE.
- `JOB_CNT`, `ERR_CNT` out 16: only with `GCD_JOB_STATS_EN`.

## Operation
- FIFO: push when `IN_VALID && IN_READY`; pop on the IDLE→ISSUE transition. A push while full is refused, even if a pop occurs in the same cycle. Push and pop together when not full are both performed, and the count is unchanged. Pointers wrap modulo DEPTH.
- Operand hold registers `GCD_A`/`GCD_B` load from the FIFO head on the pop. They stay constant until the next pop, because the core compares A==B combinationally throughout CALC.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE → ISSUE when the FIFO is non-empty.
  - ISSUE: `GCD_START`=1 for exactly one cycle; → WAIT.
  - WAIT: on `GCD_DONE`, capture `OUT_Y`←`GCD_Y` and `OUT_ERR`←`GCD_ERROR`; → HOLD.
  - WAIT: if the watchdog reaches TIMEOUT first, set `OUT_Y`=0 and `OUT_ERR`=1; → HOLD.
  - HOLD: `OUT_VALID`=1; on `OUT_READY` → IDLE.
- Watchdog counter clears in ISSUE and increments each WAIT cycle. Width is clog2(TIMEOUT+1).
- `GCD_DONE` outside WAIT is ignored.
- `OUT_Y`/`OUT_ERR` are stable while `OUT_VALID`=1.
- A zero operand is not checked locally; the core's ERROR is trusted.

## Timing
- Reset values: `IN_READY`=1 (FIFO empty). `GCD_A`, `GCD_B`, `GCD_START`, `OUT_VALID`, `OUT_Y`, `OUT_ERR`, `BUSY`, and the counters are all 0. FSM is in IDLE.
- A push into an empty idle block at edge n yields `GCD_START` high in cycle n+2 (IDLE at n+1, ISSUE at n+2).
- `OUT_VALID` rises the cycle after `GCD_DONE` is sampled.
- The next START occurs no earlier than 2 cycles after the OUT handshake.
- Reset mid-operation clears the FIFO, drops all pending jobs, and forces `GCD_START`=0 immediately.

## Configuration
- `GCD_JOB_STATS_EN` defined:
  - `JOB_CNT` increments on each OUT handshake.
  - `ERR_CNT` increments on each OUT handshake with `OUT_ERR`=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the `JOB_CNT`/`ERR_CNT` ports, registers and logic are absent. All other behaviour is identical.

## Structure
- Shared package `gcd_pkg`: the state encoding localparams (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, HOLD=2'b11), default W and default TIMEOUT.
- One sub-module: `gcd_job_fifo` (parameters W, DEPTH). It stores {A,B} and provides push/pop/full/empty/head.
- FSM, hold registers, watchdog and output register live in the top module.

## Test plan
- Push (12,18), `OUT_READY`=1, real `GCD` attached → one `GCD_START` pulse; `OUT_Y`=6, `OUT_ERR`=0; `GCD_A`/`GCD_B` constant from START to DONE.
- Push (0,5) → `OUT_ERR`=1; the next job (35,21) still yields 7 with `OUT_ERR`=0.
- Push (48,36), (7,7), (255,1), (9,6) back-to-back → results 12, 7, 1, 3 in order.
- Hold `OUT_READY`=0 and push 5 jobs with DEPTH=4:
  - After the first job completes: `OUT_VALID` stays 1 with its value, no further START.
  - 4 pending jobs fill the FIFO; `IN_READY`=0 on the fifth until `OUT_READY` is raised.
- Stub core that never asserts DONE → exactly TIMEOUT cycles after START, `OUT_VALID`=1, `OUT_Y`=0, `OUT_ERR`=1.
- Assert `RST_N`=0 during WAIT with 2 jobs queued → all outputs 0 and `IN_READY`=1 at once. After release no START is issued until a new push.
